bitrev_perm_engine: RTL

- Sequential in-place bit-reversal permutation engine for the NTT/INTT datapath.
- Walks a single-port polynomial RAM of N = 2**LOG_N coefficients. For every index i with i < rev(i), it swaps mem[i] and mem[rev(i)].
- Generalises the fixed 9-bit address map to any LOG_N and data width, and adds start/busy/done control, memory sequencing and a swap counter.
- Sits between the coefficient RAM and the NTT controller; it owns the RAM port only while busy.

---
 rtl/bitrev_perm_engine.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bitrev_perm_engine.sv
// In-place bit-reversal permutation engine: walks a single-port coefficient RAM
// and swaps mem[i] with mem[rev(i)] for every i < rev(i).
module bitrev_perm_engine #(
    parameter int unsigned LOG_N  = 9,
    parameter int unsigned DATA_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [LOG_N-1:0]  swap_cnt,
    output logic [LOG_N-1:0]  mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata
);

    localparam logic [LOG_N-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        RD_A,
        RD_B,
        CAP,
        WR_A,
        WR_B,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [LOG_N-1:0]    i_q, i_d;
    logic [LOG_N-1:0]    i_rev;
    logic [DATA_W-1:0]   a_reg, a_d;
    logic [DATA_W-1:0]   b_reg, b_d;
    logic [LOG_N-1:0]    cnt_d;
    logic [LOG_N-1:0]    addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                busy_d, done_d, re_d, we_d;

    function automatic logic [LOG_N-1:0] rev(input logic [LOG_N-1:0] x);
        logic [LOG_N-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < LOG_N; k++) begin
            r[k] = x[LOG_N-1-k];
        end
        return r;
    endfunction

    assign i_rev = rev(i_q);

    // Next state plus next values of every register; outputs are decoded from
    // the next state so they line up with the state they belong to.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        a_d     = a_reg;
        b_d     = b_reg;
        cnt_d   = swap_cnt;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    i_d     = '0;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (i_q < i_rev) begin
                    state_d = RD_A;
                end else if (i_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    i_d = i_q + LOG_N'(1);
                end
            end
            RD_A: state_d = RD_B;
            RD_B: begin
                a_d     = mem_rdata;
                state_d = CAP;
            end
            CAP: begin
                b_d     = mem_rdata;
                state_d = WR_A;
            end
            WR_A: state_d = WR_B;
            WR_B: begin
                cnt_d   = swap_cnt + LOG_N'(1);
                i_d     = i_q + LOG_N'(1);
                state_d = SCAN;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
        re_d   = (state_d == RD_A) || (state_d == RD_B);
        we_d   = (state_d == WR_A) || (state_d == WR_B);

        // i is stable across RD_A..WR_B, so the current i addresses the pair
        case (state_d)
            RD_A: addr_d = i_q;
            RD_B: addr_d = i_rev;
            WR_A: begin
                addr_d  = i_q;
                wdata_d = b_d;
            end
            WR_B: begin
                addr_d  = i_rev;
                wdata_d = a_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            i_q       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            swap_cnt  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            a_reg     <= a_d;
            b_reg     <= b_d;
            swap_cnt  <= cnt_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            busy      <= busy_d;
            done      <= done_d;
            mem_re    <= re_d;
            mem_we    <= we_d;
        end
    end

endmodule
